int_res_mem_ctrl: RTL

INT_RES_MEM_CTRL -- requirements
Module: int_res_mem_ctrl

---
 rtl/int_res_mem_ctrl.sv | 130 +++++++++++++
 1 files changed

// File: rtl/int_res_mem_ctrl.sv
// Two-bank memory controller. It stores 16-bit saturated SINGLE words or
// 32-bit DOUBLE words that span both banks at the same row. Writes win a
// bank conflict, and reads complete with a fixed two-cycle latency.
module int_res_mem_ctrl #(
  parameter int ADDR_W  = 13,
  parameter int DATA_W  = 32,
  parameter int BANK_W  = 16,
  parameter int BANK_AW = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [DATA_W-1:0]  wr_data,
  input  logic               wr_width,
  input  logic               rd_en,
  input  logic [ADDR_W-1:0]  rd_addr,
  input  logic               rd_width,
  output logic               rd_ready,
  output logic [DATA_W-1:0]  rd_data,
  output logic               rd_valid,
  output logic               err_misaligned,
  output logic               bank0_en,
  output logic               bank0_wen,
  output logic [BANK_AW-1:0] bank0_addr,
  output logic [BANK_W-1:0]  bank0_wdata,
  input  logic [BANK_W-1:0]  bank0_rdata,
  output logic               bank1_en,
  output logic               bank1_wen,
  output logic [BANK_AW-1:0] bank1_addr,
  output logic [BANK_W-1:0]  bank1_wdata,
  input  logic [BANK_W-1:0]  bank1_rdata
);

  logic               wr_mis, wr_b0, wr_b1;
  logic               rd_b0, rd_b1, rd_go, conflict;
  logic [BANK_AW-1:0] wr_row, rd_row;
  logic [BANK_W-1:0]  wr_sat, wr_lo, wr_hi, rd_sel;

  // in-flight read pipeline: stage 1 tracks the bank access cycle
  logic               p_valid, p_dbl, p_sel, p_mis;
  logic               rd_valid_q, err_q;
  logic [DATA_W-1:0]  rd_data_q;

  assign wr_row = wr_addr[ADDR_W-1:1];
  assign rd_row = rd_addr[ADDR_W-1:1];

  // A misaligned DOUBLE touches no bank, so it can never conflict.
  assign wr_mis   = wr_en & wr_width & wr_addr[0];
  assign wr_b0    = ~rst & wr_en & ~wr_addr[0];
  assign wr_b1    = ~rst & wr_en & (wr_width ? ~wr_addr[0] : wr_addr[0]);
  assign rd_b0    = rd_en & ~rd_addr[0];
  assign rd_b1    = rd_en & (rd_width ? ~rd_addr[0] : rd_addr[0]);
  assign conflict = (wr_b0 & rd_b0) | (wr_b1 & rd_b1);
  assign rd_go    = ~rst & rd_en & ~conflict;
  assign rd_ready = rd_go;

  // clamp SINGLE write data to the signed bank-word range
  always_comb begin
    wr_sat = wr_data[BANK_W-1:0];
    if (wr_data[DATA_W-1:BANK_W-1] != {(DATA_W-BANK_W+1){wr_data[DATA_W-1]}})
      wr_sat = wr_data[DATA_W-1] ? {1'b1, {(BANK_W-1){1'b0}}}
                                 : {1'b0, {(BANK_W-1){1'b1}}};
  end

  assign wr_lo = wr_width ? wr_data[BANK_W-1:0] : wr_sat;
  assign wr_hi = wr_width ? wr_data[DATA_W-1:BANK_W] : wr_sat;

  // combinational bank strobes; an unused bank is driven all-zero
  always_comb begin
    bank0_en    = wr_b0 | (rd_go & rd_b0);
    bank0_wen   = wr_b0;
    bank0_addr  = '0;
    bank0_wdata = '0;
    if (wr_b0) begin
      bank0_addr  = wr_row;
      bank0_wdata = wr_lo;
    end else if (rd_go & rd_b0) begin
      bank0_addr  = rd_row;
    end
    bank1_en    = wr_b1 | (rd_go & rd_b1);
    bank1_wen   = wr_b1;
    bank1_addr  = '0;
    bank1_wdata = '0;
    if (wr_b1) begin
      bank1_addr  = wr_row;
      bank1_wdata = wr_hi;
    end else if (rd_go & rd_b1) begin
      bank1_addr  = rd_row;
    end
  end

  assign rd_sel = p_sel ? bank1_rdata : bank0_rdata;

  // read pipeline, result register and sticky misalignment flag
  always_ff @(posedge clk) begin
    if (rst) begin
      p_valid    <= 1'b0;
      p_dbl      <= 1'b0;
      p_sel      <= 1'b0;
      p_mis      <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      p_valid    <= rd_go;
      p_dbl      <= rd_width;
      p_sel      <= rd_addr[0];
      p_mis      <= rd_width & rd_addr[0];
      rd_valid_q <= p_valid;
      if (p_valid) begin
        if (p_mis)
          rd_data_q <= '0;
        else if (p_dbl)
          rd_data_q <= {bank1_rdata, bank0_rdata};
        else
          rd_data_q <= {{(DATA_W-BANK_W){rd_sel[BANK_W-1]}}, rd_sel};
      end
      if (wr_mis | (rd_go & rd_width & rd_addr[0]))
        err_q <= 1'b1;
    end
  end

  // Outputs read as zero for the whole reset cycle, including the one
  // before the first reset edge.
  assign rd_valid       = rd_valid_q & ~rst;
  assign rd_data        = rst ? '0 : rd_data_q;
  assign err_misaligned = err_q & ~rst;

endmodule
